output_display_module: RTL and testbench

OUTPUT_DISPLAY_MODULE -- requirements
Module: output_display_module

---
 rtl/output_display_module.sv | 222 ++++++++++++++++++++++
 tb/tb_output_display_module.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/output_display_module.sv
// Double-dabble BCD converter feeding a 4-digit multiplexed active-low 7-segment display.
// Define OUTPUT_SIGNED_EN to treat data as two's complement and show a minus sign on dig[3].
module output_display_module #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       load,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] dig
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Digit codes beyond 0..9 select the non-numeric glyphs.
    localparam logic [3:0]  CODE_BLANK = 4'hA;
    localparam logic [3:0]  CODE_MINUS = 4'hB;
    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 32'd1);

    function automatic logic [3:0] add3(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    // Returns {negative, magnitude} of the value about to be converted.
    function automatic logic [8:0] prep_word(input logic [7:0] v);
`ifdef OUTPUT_SIGNED_EN
        if (v[7]) begin
            return {1'b1, ~v + 8'd1};
        end else begin
            return {1'b0, v};
        end
`else
        return {1'b0, v};
`endif
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:       return 8'hC0;
            4'd1:       return 8'hF9;
            4'd2:       return 8'hA4;
            4'd3:       return 8'hB0;
            4'd4:       return 8'h99;
            4'd5:       return 8'h92;
            4'd6:       return 8'h82;
            4'd7:       return 8'hF8;
            4'd8:       return 8'h80;
            4'd9:       return 8'h90;
            CODE_MINUS: return 8'hBF;
            default:    return 8'hFF;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        busy_q, busy_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  sign_q, sign_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  dig_q, dig_d;

    logic [7:0]  src_s;
    logic [8:0]  src_word_s;
    logic [11:0] adj_s;
    logic [3:0]  code_s;

    // Conversion FSM, pending-load capture and display register update.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        hund_d      = hund_q;
        sign_d      = sign_q;
        busy_d      = (state_q == CONVERT) || ((state_q == DONE) && pend_q);
        src_s       = ((state_q == IDLE) && load) ? data : pend_data_q;
        src_word_s  = prep_word(src_s);
        adj_s       = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

        if (load && (state_q != IDLE)) begin
            pend_d      = 1'b1;
            pend_data_d = data;
        end else begin
            pend_d      = pend_q;
        end

        case (state_q)
            IDLE: begin
                if (load || pend_q) begin
                    state_d = CONVERT;
                    sr_d    = src_word_s[7:0];
                    neg_d   = src_word_s[8];
                    bcd_d   = 12'd0;
                    cnt_d   = 4'd0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                if (cnt_q == 4'd8) begin
                    state_d = DONE;
                end else begin
                    {bcd_d, sr_d} = {adj_s, sr_q} << 1;
                    cnt_d         = cnt_q + 4'd1;
                end
            end
            DONE: begin
                hund_d = (bcd_q[11:8] == 4'd0) ? CODE_BLANK : bcd_q[11:8];
                tens_d = (bcd_q[11:4] == 8'd0) ? CODE_BLANK : bcd_q[7:4];
                ones_d = bcd_q[3:0];
                sign_d = neg_q ? CODE_MINUS : CODE_BLANK;
                // A load landing in this same cycle re-arms pending with the new data.
                if (pend_q) begin
                    state_d = CONVERT;
                    sr_d    = src_word_s[7:0];
                    neg_d   = src_word_s[8];
                    bcd_d   = 12'd0;
                    cnt_d   = 4'd0;
                    pend_d  = load;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scan prescaler, digit index and glyph selection for the next digit shown.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        code_s  = CODE_BLANK;
        if (presc_q == SCAN_LAST) begin
            presc_d = 16'd0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + 16'd1;
            idx_d   = idx_q;
        end
        // Uses the next display contents so seg tracks a display update on the same edge.
        case (idx_d)
            2'd0:    code_s = ones_d;
            2'd1:    code_s = tens_d;
            2'd2:    code_s = hund_d;
            2'd3:    code_s = sign_d;
            default: code_s = CODE_BLANK;
        endcase
        seg_d = glyph(code_s);
        dig_d = ~(4'b0001 << idx_d);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= 8'd0;
            bcd_q       <= 12'd0;
            cnt_q       <= 4'd0;
            neg_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'd0;
            busy_q      <= 1'b0;
            ones_q      <= 4'd0;
            tens_q      <= CODE_BLANK;
            hund_q      <= CODE_BLANK;
            sign_q      <= CODE_BLANK;
            presc_q     <= 16'd0;
            idx_q       <= 2'd0;
            seg_q       <= 8'hC0;
            dig_q       <= 4'b1110;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            busy_q      <= busy_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            hund_q      <= hund_d;
            sign_q      <= sign_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign dig  = dig_q;

endmodule

// File: tb/tb_output_display_module.sv
// Directed bench for output_display_module: reset scan, conversions, pending loads, reset abort.
module tb_output_display_module;

    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       load;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] dig;

    int tests = 0;
    int fails = 0;

    output_display_module #(.SCAN_DIV(SD)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .load (load),
        .busy (busy),
        .seg  (seg),
        .dig  (dig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the given digit to be enabled, then checks its glyph.
    task automatic check_digit(input string tag, input int idx, input logic [7:0] exp);
        logic [3:0] tgt;
        logic [7:0] got;
        tgt = ~(4'b0001 << idx);
        got = 8'hxx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dig === tgt) begin
                got = seg;
                break;
            end
        end
        chk(tag, {24'd0, got}, {24'd0, exp});
    endtask

    task automatic check_display(input string tag, input logic [7:0] e_sign, input logic [7:0] e_hund,
                                 input logic [7:0] e_tens, input logic [7:0] e_ones);
        check_digit({tag, "_ones"}, 0, e_ones);
        check_digit({tag, "_tens"}, 1, e_tens);
        check_digit({tag, "_hund"}, 2, e_hund);
        check_digit({tag, "_sign"}, 3, e_sign);
    endtask

    // Called at the negedge right after the reset edge; checks the reset scan pattern cycle by cycle.
    task automatic check_reset_scan(input string tag, input int cycles);
        int errs;
        int idx;
        logic [3:0] e_dig;
        logic [7:0] e_seg;
        errs = 0;
        for (int c = 0; c < cycles; c++) begin
            idx   = (c / SD) % 4;
            e_dig = ~(4'b0001 << idx);
            e_seg = (idx == 0) ? 8'hC0 : 8'hFF;
            if (dig !== e_dig || seg !== e_seg || busy !== 1'b0) errs++;
            @(negedge clk);
        end
        chk(tag, errs, 32'd0);
    endtask

    // Drives load for one edge; returns at the negedge after that edge.
    task automatic do_load(input logic [7:0] d);
        data = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic [11:0] trace12;
    logic [29:0] trace30;
    logic [7:0]  tens_a, ones_a, tens_b, ones_b;
    logic        saw52;

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_seg", {24'd0, seg}, 32'h0000_00C0);
        chk("rst_dig", {28'd0, dig}, 32'h0000_000E);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        check_reset_scan("rst_scan", 4 * SD * 2);

        // 0xFF: busy profile and display
        do_load(8'hFF);
        for (int k = 0; k < 12; k++) begin
            trace12[k] = busy;
            @(negedge clk);
        end
        chk("ff_busy_trace", {20'd0, trace12}, 32'h0000_03FE);
`ifdef OUTPUT_SIGNED_EN
        check_display("ff", 8'hBF, 8'hFF, 8'hFF, 8'hF9);
`else
        check_display("ff", 8'hFF, 8'hA4, 8'h92, 8'h92);
`endif

        do_load(8'h07);
        repeat (12) @(negedge clk);
        check_display("d07", 8'hFF, 8'hFF, 8'hFF, 8'hF8);

        do_load(8'h0A);
        repeat (12) @(negedge clk);
        check_display("d0a", 8'hFF, 8'hFF, 8'hF9, 8'hC0);

`ifdef OUTPUT_SIGNED_EN
        do_load(8'h80);
        repeat (12) @(negedge clk);
        check_display("s80", 8'hBF, 8'hF9, 8'hA4, 8'h80);

        do_load(8'h7F);
        repeat (12) @(negedge clk);
        check_display("s7f", 8'hFF, 8'hF9, 8'hA4, 8'hF8);
`endif

        // 0x12 then 0x34, 0x56 while busy: 18 then 86, never 52
        tens_a = 8'hxx;
        ones_a = 8'hxx;
        tens_b = 8'hxx;
        ones_b = 8'hxx;
        saw52  = 1'b0;
        do_load(8'h12);
        for (int k = 0; k < 30; k++) begin
            trace30[k] = busy;
            if (dig === 4'b1101 && seg === 8'h92) saw52 = 1'b1;
            if (k >= 10 && k < 20) begin
                if (dig === 4'b1101) tens_a = seg;
                if (dig === 4'b1110) ones_a = seg;
            end
            if (k >= 20) begin
                if (dig === 4'b1101) tens_b = seg;
                if (dig === 4'b1110) ones_b = seg;
            end
            load = (k == 2) || (k == 4);
            data = (k == 2) ? 8'h34 : 8'h56;
            @(negedge clk);
        end
        load = 1'b0;
        chk("pend_busy_trace", {2'd0, trace30}, 32'h000F_FFFE);
        chk("pend_first_tens", {24'd0, tens_a}, 32'h0000_00F9);
        chk("pend_first_ones", {24'd0, ones_a}, 32'h0000_0080);
        chk("pend_last_tens", {24'd0, tens_b}, 32'h0000_0080);
        chk("pend_last_ones", {24'd0, ones_b}, 32'h0000_0082);
        chk("pend_never_52", {31'd0, saw52}, 32'd0);
        check_digit("pend_hund", 2, 8'hFF);

        // reset 4 cycles into a conversion of 0xC8, with a competing load on the reset edge
        do_load(8'hC8);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        data = 8'h33;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        check_reset_scan("abort_scan", 4 * SD * 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
